mem_line_arbiter: RTL

Two-port line-request arbiter and latency sequencer between the instruction cache, the data cache, and the 128-bit line RAM. Accepts one miss-fill (read) or write-back (write) line request at a time and drives the RAM's read address, write address, write data and write enable. Models a fixed multi-cycle memory latency and returns the fetched line with a one-cycle ready pulse. The RAM itself stays a combinational array.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_rr_arbiter.sv | 36 +++
 rtl/mem_line_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared widths and enumerations for the line-RAM arbiter and its round-robin helper.
package mem_pkg;

    localparam int LINE_W  = 128;
    localparam int LADDR_W = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-input round-robin picker; the last_grant pointer only moves when the grant is taken.
module mem_rr_arbiter
    import mem_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req_ic,
    input  logic   i_req_dc,
    input  logic   i_accept,
    output grant_t o_grant,
    output logic   o_any_req
);

    grant_t r_last_grant;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        o_grant = GNT_IC;
        if (i_req_ic && i_req_dc) begin
            o_grant = (r_last_grant == GNT_IC) ? GNT_DC : GNT_IC;
        end else if (i_req_dc) begin
            o_grant = GNT_DC;
        end
    end

    assign o_any_req = i_req_ic | i_req_dc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= GNT_IC;
        end else if (i_accept) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a combinational line RAM and
// sequences a fixed access latency. Handshake: req is a level held until its one-cycle ready.
module mem_line_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 5
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                ic_req,
    input  logic [LADDR_W-1:0]  ic_addr,
    output logic                ic_ready,
    input  logic                dc_req,
    input  logic                dc_we,
    input  logic [LADDR_W-1:0]  dc_addr,
    input  logic [LINE_W-1:0]   dc_wdata,
    output logic                dc_ready,
    output logic [LINE_W-1:0]   rdata,
    output logic                busy,
    output logic [LADDR_W-1:0]  mem_rd_addr,
    output logic [LADDR_W-1:0]  mem_wr_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [LINE_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    grant_t               r_gnt;
    logic                 r_we;
    logic [LADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]    r_wdata;
    logic [LINE_W-1:0]    r_rdata;

    grant_t               w_grant;
    logic                 w_any_req;
    logic                 w_accept;
    logic                 w_access;

    assign w_accept = (r_state == IDLE) && w_any_req;
    assign w_access = (r_state == BUSY) && (r_cnt == '0);

    mem_rr_arbiter u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req_ic  (ic_req),
        .i_req_dc  (dc_req),
        .i_accept  (w_accept),
        .o_grant   (w_grant),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gnt   <= GNT_IC;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_LOAD;
                        r_gnt   <= w_grant;
                        // I-cache has no write path, so its grant leaves the write data alone.
                        if (w_grant == GNT_DC) begin
                            r_addr  <= dc_addr;
                            r_we    <= dc_we;
                            r_wdata <= dc_wdata;
                        end else begin
                            r_addr  <= ic_addr;
                            r_we    <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ic_ready    = (r_state == DONE) && (r_gnt == GNT_IC);
    assign dc_ready    = (r_state == DONE) && (r_gnt == GNT_DC);
    assign busy        = (r_state != IDLE);
    assign mem_we      = w_access && r_we;
    assign mem_rd_addr = r_addr;
    assign mem_wr_addr = r_addr;
    assign mem_wdata   = r_wdata;
    assign rdata       = r_rdata;
    assign dbg_state   = r_state;

endmodule
